// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, pairs each
// returned word with its PC and buffers if_id records {pc, pc4, instruction} for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [95:0] if_id
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high
    // at the rising edge; the responder never back-pressures imem_rsp_valid.

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pcf_mem [DEPTH];
    logic [PW-1:0] pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
    logic [95:0]   buf_mem [DEPTH];
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          issue, rsp_acc, buf_push, buf_pop;
    logic [31:0]   rsp_pc;

    always_comb begin
        // Credits cover both in-flight fetches and buffered records, so a kept
        // response always finds a free buffer slot.
        imem_req_valid = nrst && !redirect_valid
                         && (({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < DEPTH_C);
        imem_req_addr  = pc_q;
        issue          = imem_req_valid && imem_req_ready;
        rsp_acc        = imem_rsp_valid && (inflight_q != '0);
        rsp_pc         = pcf_mem[pcf_rd_q];
        if_id_valid    = (buf_cnt_q != '0);
        if_id          = if_id_valid ? buf_mem[buf_rd_q] : '0;
        buf_push       = rsp_acc && (drop_q == '0) && !redirect_valid;
        buf_pop        = if_id_valid && id_ready && !redirect_valid;

        pc_d       = issue ? pc_q + 32'd4 : pc_q;
        pcf_wr_d   = pcf_wr_q + PW'(issue);
        pcf_rd_d   = pcf_rd_q + PW'(rsp_acc);
        inflight_d = inflight_q + CW'(issue) - CW'(rsp_acc);
        buf_wr_d   = buf_wr_q + PW'(buf_push);
        buf_rd_d   = buf_rd_q + PW'(buf_pop);
        buf_cnt_d  = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
        drop_d     = drop_q;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle predates the redirect.
            pc_d      = {redirect_pc[31:2], 2'b00};
            drop_d    = inflight_q - CW'(rsp_acc);
            buf_wr_d  = '0;
            buf_rd_d  = '0;
            buf_cnt_d = '0;
        end else if (rsp_acc && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc_q       <= RESET_PC;
            pcf_wr_q   <= '0;
            pcf_rd_q   <= '0;
            inflight_q <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pcf_wr_q   <= pcf_wr_d;
            pcf_rd_q   <= pcf_rd_d;
            inflight_q <= inflight_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            buf_cnt_q  <= buf_cnt_d;
            drop_q     <= drop_d;
        end
    end

    // Storage arrays carry no reset; pointers and counts qualify every read.
    always_ff @(posedge clk) begin
        if (issue) begin
            pcf_mem[pcf_wr_q] <= pc_q;
        end
        if (buf_push) begin
            buf_mem[buf_wr_q] <= {rsp_pc, rsp_pc + 32'd4, imem_rsp_data};
        end
    end

    rsp_without_request_a: assert property (
        @(posedge clk) disable iff (!nrst) imem_rsp_valid |-> (inflight_q != '0));

endmodule
